// File: rtl/delay_pkg.sv
// Shared definitions for the delay_master request arbiter and its helpers.
package delay_pkg;

    // Requester operation codes as presented on req_op.
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_ALLOC = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    // Arbiter transaction states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    // Fractional bits of delay values (Q8) exchanged with delay_master.
    localparam int DELAY_FORMAT = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority encoder: the first set request at or
// after index rr (wrapping) wins. Reusable by any shared-resource scheduler.
module rr_arbiter #(
    parameter int n_req = 4
) (
    input  logic [n_req-1:0]         req,
    input  logic [$clog2(n_req)-1:0] rr,
    output logic [n_req-1:0]         grant,
    output logic [$clog2(n_req)-1:0] idx,
    output logic                     any
);
    localparam int IDX_W = $clog2(n_req);

    logic [IDX_W:0] pos;

    // Walk offsets farthest-first so the nearest requester after rr is the last writer.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        for (int k = n_req - 1; k >= 0; k--) begin
            pos = {1'b0, rr} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(n_req)) pos = pos - (IDX_W+1)'(n_req);
            if (req[pos[IDX_W-1:0]]) begin
                idx = pos[IDX_W-1:0];
                any = 1'b1;
            end
        end
        if (any) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/delay_request_arbiter.sv
// Shares one delay_master port between n_req requesters: round-robin grant,
// one outstanding operation, completion/error/timeout routed back one-hot.
module delay_request_arbiter
    import delay_pkg::*;
#(
    parameter int n_req          = 4,
    parameter int data_width     = 16,
    parameter int handle_width   = 5,
    parameter int alloc_width    = 24,
    parameter int timeout_cycles = 63
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [n_req-1:0]                    req_valid,
    input  logic [n_req-1:0][1:0]               req_op,
    input  logic [n_req-1:0][handle_width-1:0]  req_handle,
    input  logic [n_req-1:0][data_width-1:0]    req_data,
    input  logic [n_req-1:0][data_width-1:0]    req_inc,
    input  logic [n_req-1:0][alloc_width-1:0]   req_size,
    input  logic [n_req-1:0][alloc_width-1:0]   req_delay,
    output logic [n_req-1:0]                    req_ready,
    output logic [n_req-1:0]                    resp_valid,
    output logic [data_width-1:0]               resp_data,
    output logic                                resp_err,
    output logic                                dm_alloc_req,
    output logic                                dm_read_req,
    output logic                                dm_write_req,
    output logic [alloc_width-1:0]              dm_alloc_size,
    output logic [alloc_width-1:0]              dm_alloc_delay,
    output logic [handle_width-1:0]             dm_read_handle,
    output logic [handle_width-1:0]             dm_write_handle,
    output logic [data_width-1:0]               dm_write_data,
    output logic [data_width-1:0]               dm_write_inc,
    input  logic [data_width-1:0]               dm_data_out,
    input  logic                                dm_read_valid,
    input  logic                                dm_write_ack,
    input  logic                                dm_invalid_alloc,
    input  logic                                dm_invalid_read,
    input  logic                                dm_invalid_write,
    output logic                                busy
);
    localparam int IDX_W = $clog2(n_req);
    localparam int CNT_W = $clog2(timeout_cycles + 1);

    state_e             state;
    op_e                op;
    logic [IDX_W-1:0]   rr;
    logic [IDX_W-1:0]   gidx;
    logic [CNT_W-1:0]   cnt;
    logic [n_req-1:0]   grant;
    logic [IDX_W-1:0]   widx;
    logic               any;
    logic               done;
    logic               err;

    rr_arbiter #(.n_req(n_req)) u_arb (
        .req   (req_valid),
        .rr    (rr),
        .grant (grant),
        .idx   (widx),
        .any   (any)
    );

    // Grant is only offered in IDLE; fields are sampled on the same edge.
    assign req_ready = (state == ST_IDLE && reset) ? grant : '0;
    assign busy      = (state != ST_IDLE);

    // Completion decode while waiting; errors win over success, timeout is the backstop.
    always_comb begin
        done = 1'b0;
        err  = 1'b0;
        case (op)
            OP_READ: begin
                if (dm_invalid_read) begin
                    done = 1'b1;
                    err  = 1'b1;
                end else if (dm_read_valid) begin
                    done = 1'b1;
                end
            end
            OP_WRITE: begin
                if (dm_invalid_write) begin
                    done = 1'b1;
                    err  = 1'b1;
                end else if (dm_write_ack) begin
                    done = 1'b1;
                end
            end
            OP_ALLOC: begin
                // No success ack exists for alloc: error only in the first wait cycle.
                if (cnt == '0 && dm_invalid_alloc) begin
                    done = 1'b1;
                    err  = 1'b1;
                end else if (cnt == CNT_W'(1)) begin
                    done = 1'b1;
                end
            end
            default: begin
                done = 1'b1;
                err  = 1'b1;
            end
        endcase
        if (!done && cnt == CNT_W'(timeout_cycles - 1)) begin
            done = 1'b1;
            err  = 1'b1;
        end
    end

    // Transaction FSM with registered strobes, buses and response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            op              <= OP_READ;
            rr              <= '0;
            gidx            <= '0;
            cnt             <= '0;
            dm_alloc_req    <= 1'b0;
            dm_read_req     <= 1'b0;
            dm_write_req    <= 1'b0;
            dm_alloc_size   <= '0;
            dm_alloc_delay  <= '0;
            dm_read_handle  <= '0;
            dm_write_handle <= '0;
            dm_write_data   <= '0;
            dm_write_inc    <= '0;
            resp_valid      <= '0;
            resp_data       <= '0;
            resp_err        <= 1'b0;
        end else begin
            dm_alloc_req <= 1'b0;
            dm_read_req  <= 1'b0;
            dm_write_req <= 1'b0;
            resp_valid   <= '0;
            resp_err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        gidx <= widx;
                        op   <= op_e'(req_op[widx]);
                        rr   <= (widx == IDX_W'(n_req - 1)) ? '0 : widx + 1'b1;
                        state <= ST_ISSUE;
                        // Only the bus set matching the op is reloaded; the rest hold.
                        case (op_e'(req_op[widx]))
                            OP_READ: begin
                                dm_read_req    <= 1'b1;
                                dm_read_handle <= req_handle[widx];
                            end
                            OP_WRITE: begin
                                dm_write_req    <= 1'b1;
                                dm_write_handle <= req_handle[widx];
                                dm_write_data   <= req_data[widx];
                                dm_write_inc    <= req_inc[widx];
                            end
                            OP_ALLOC: begin
                                dm_alloc_req   <= 1'b1;
                                dm_alloc_size  <= req_size[widx];
                                dm_alloc_delay <= req_delay[widx];
                            end
                            default: begin
                                state            <= ST_RESP;
                                resp_valid[widx] <= 1'b1;
                                resp_err         <= 1'b1;
                                resp_data        <= '0;
                            end
                        endcase
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (done) begin
                        state            <= ST_RESP;
                        resp_valid[gidx] <= 1'b1;
                        resp_err         <= err;
                        resp_data        <= (op == OP_READ && !err) ? dm_data_out : '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_request_arbiter.sv
// Randomized bench: transaction-level model predicts grant order, strobe and
// response timing, and response contents from the arbitration rules.
module tb_delay_request_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int HW = 5;
    localparam int AW = 24;
    localparam int TO = 63;

    logic                clk = 1'b0;
    logic                reset;
    logic [NR-1:0]       req_valid;
    logic [NR-1:0][1:0]  req_op;
    logic [NR-1:0][HW-1:0] req_handle;
    logic [NR-1:0][DW-1:0] req_data;
    logic [NR-1:0][DW-1:0] req_inc;
    logic [NR-1:0][AW-1:0] req_size;
    logic [NR-1:0][AW-1:0] req_delay;
    logic [NR-1:0]       req_ready;
    logic [NR-1:0]       resp_valid;
    logic [DW-1:0]       resp_data;
    logic                resp_err;
    logic                dm_alloc_req, dm_read_req, dm_write_req;
    logic [AW-1:0]       dm_alloc_size, dm_alloc_delay;
    logic [HW-1:0]       dm_read_handle, dm_write_handle;
    logic [DW-1:0]       dm_write_data, dm_write_inc;
    logic [DW-1:0]       dm_data_out;
    logic                dm_read_valid, dm_write_ack;
    logic                dm_invalid_alloc, dm_invalid_read, dm_invalid_write;
    logic                busy;

    delay_request_arbiter #(
        .n_req(NR), .data_width(DW), .handle_width(HW),
        .alloc_width(AW), .timeout_cycles(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_handle(req_handle),
        .req_data(req_data), .req_inc(req_inc), .req_size(req_size), .req_delay(req_delay),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .dm_alloc_req(dm_alloc_req), .dm_read_req(dm_read_req), .dm_write_req(dm_write_req),
        .dm_alloc_size(dm_alloc_size), .dm_alloc_delay(dm_alloc_delay),
        .dm_read_handle(dm_read_handle), .dm_write_handle(dm_write_handle),
        .dm_write_data(dm_write_data), .dm_write_inc(dm_write_inc),
        .dm_data_out(dm_data_out), .dm_read_valid(dm_read_valid), .dm_write_ack(dm_write_ack),
        .dm_invalid_alloc(dm_invalid_alloc), .dm_invalid_read(dm_invalid_read),
        .dm_invalid_write(dm_invalid_write), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state
    int            cyc, rr_m, g_m, op_m, strobe_cyc, resp_cyc, kind, plan_k, clear_r, req_pct;
    bit            active, inv, exp_err, chk_d, rd_known, did_to;
    logic [DW-1:0] exp_rdata, rd_val, last_rd;
    logic [HW-1:0] f_h, e_rh, e_wh;
    logic [DW-1:0] f_d, f_i, e_wd, e_wi;
    logic [AW-1:0] f_s, f_dl, e_as, e_ad;
    logic [NR-1:0] force_req;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, "_rdy"},  64'(req_ready), 0);
        chk({tag, "_rv"},   64'(resp_valid), 0);
        chk({tag, "_rd"},   64'(resp_data), 0);
        chk({tag, "_re"},   64'(resp_err), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_str"},  64'({dm_alloc_req, dm_read_req, dm_write_req}), 0);
        chk({tag, "_abus"}, 64'({dm_alloc_size, dm_alloc_delay}), 0);
        chk({tag, "_wbus"}, 64'({dm_write_handle, dm_write_data, dm_write_inc, dm_read_handle}), 0);
    endtask

    task automatic rand_fields(input int r);
        req_handle[r] = HW'($urandom);
        req_data[r]   = DW'($urandom);
        req_inc[r]    = DW'($urandom);
        req_size[r]   = AW'($urandom);
        req_delay[r]  = AW'($urandom);
    endtask

    task automatic step();
        int win, wi, v;
        bit ok, er;
        logic [NR-1:0] exp_rdy, exp_rv;
        logic [2:0]    exp_str;
        @(negedge clk);
        cyc++;
        if (active && cyc > resp_cyc) active = 0;

        // registered outputs
        chk("busy", 64'(busy), 64'(active));
        exp_str = 3'b000;
        if (active && cyc == strobe_cyc) begin
            case (op_m)
                0: begin exp_str = 3'b010; e_rh = f_h; end
                1: begin exp_str = 3'b001; e_wh = f_h; e_wd = f_d; e_wi = f_i; end
                default: begin exp_str = 3'b100; e_as = f_s; e_ad = f_dl; end
            endcase
        end
        chk("strobe", 64'({dm_alloc_req, dm_read_req, dm_write_req}), 64'(exp_str));
        chk("rd_handle", 64'(dm_read_handle), 64'(e_rh));
        chk("wr_handle", 64'(dm_write_handle), 64'(e_wh));
        chk("wr_data", 64'(dm_write_data), 64'(e_wd));
        chk("wr_inc", 64'(dm_write_inc), 64'(e_wi));
        chk("al_size", 64'(dm_alloc_size), 64'(e_as));
        chk("al_delay", 64'(dm_alloc_delay), 64'(e_ad));
        exp_rv = '0;
        if (active && cyc == resp_cyc) exp_rv[g_m] = 1'b1;
        chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
        chk("resp_err", 64'(resp_err), (exp_rv != 0) ? 64'(exp_err) : 64'(0));
        if (exp_rv != 0) begin
            if (chk_d) begin
                chk("resp_data", 64'(resp_data), 64'(exp_rdata));
                last_rd  = exp_rdata;
                rd_known = 1;
            end else begin
                rd_known = 0;
            end
        end else if (rd_known) begin
            chk("resp_hold", 64'(resp_data), 64'(last_rd));
        end

        // delay_master responder for this cycle
        dm_read_valid = 0; dm_write_ack = 0; dm_invalid_alloc = 0;
        dm_invalid_read = 0; dm_invalid_write = 0;
        dm_data_out = DW'($urandom);
        if (active && op_m != 3 && cyc > strobe_cyc && cyc < resp_cyc) begin
            wi = cyc - strobe_cyc;
            if (op_m == 2) begin
                if (inv && wi == 1) dm_invalid_alloc = 1;
            end else if (kind != 9 && wi == plan_k) begin
                ok = (kind < 5) || (kind >= 7);
                er = (kind >= 5);
                if (op_m == 0) begin
                    dm_read_valid = ok; dm_invalid_read = er;
                    if (kind < 5) dm_data_out = rd_val;
                end else begin
                    dm_write_ack = ok; dm_invalid_write = er;
                end
            end
        end else if ($urandom_range(0, 3) == 0) begin
            {dm_read_valid, dm_write_ack, dm_invalid_alloc, dm_invalid_read, dm_invalid_write} = 5'($urandom);
        end

        // requesters
        if (force_req != 0) begin
            req_valid = force_req;
            for (int r = 0; r < NR; r++) if (force_req[r]) begin
                req_op[r] = 2'b01;
                rand_fields(r);
            end
            force_req = '0;
        end else begin
            if (clear_r >= 0) req_valid[clear_r] = 1'b0;
            for (int r = 0; r < NR; r++) begin
                if (!req_valid[r]) begin
                    if ($urandom_range(0, 99) < req_pct) begin
                        v = int'($urandom_range(0, 9));
                        req_valid[r] = 1'b1;
                        req_op[r] = (v < 4) ? 2'd0 : (v < 7) ? 2'd1 : (v < 9) ? 2'd2 : 2'd3;
                        rand_fields(r);
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    req_valid[r] = 1'b0;
                end
            end
        end
        clear_r = -1;

        // grant prediction against the inputs the next edge will see
        #1;
        win = -1;
        exp_rdy = '0;
        if (!active) begin
            for (int k = 0; k < NR; k++) begin
                if (win < 0 && req_valid[(rr_m + k) % NR]) win = (rr_m + k) % NR;
            end
        end
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("ready", 64'(req_ready), 64'(exp_rdy));
        if (win >= 0) begin
            active  = 1;
            g_m     = win;
            op_m    = int'(req_op[win]);
            rr_m    = (win + 1) % NR;
            clear_r = win;
            f_h = req_handle[win]; f_d = req_data[win]; f_i = req_inc[win];
            f_s = req_size[win];   f_dl = req_delay[win];
            chk_d = 1;
            if (op_m == 3) begin
                strobe_cyc = -10;
                resp_cyc   = cyc + 1;
                exp_err    = 1;
                exp_rdata  = '0;
            end else begin
                strobe_cyc = cyc + 1;
                if (op_m == 2) begin
                    inv       = ($urandom_range(0, 2) == 0);
                    resp_cyc  = strobe_cyc + (inv ? 2 : 3);
                    exp_err   = inv;
                    exp_rdata = '0;
                    chk_d     = inv;
                end else begin
                    kind = int'($urandom_range(0, 9));
                    if (op_m == 0 && !did_to) begin
                        kind   = 9;
                        did_to = 1;
                    end
                    plan_k    = int'($urandom_range(1, 4));
                    rd_val    = DW'($urandom);
                    resp_cyc  = (kind == 9) ? strobe_cyc + TO + 1 : strobe_cyc + plan_k + 1;
                    exp_err   = (kind >= 5);
                    exp_rdata = (op_m == 0 && kind < 5) ? rd_val : '0;
                    chk_d     = (op_m == 0) || exp_err;
                end
            end
        end
    endtask

    task automatic model_reset();
        active = 0; rr_m = 0; clear_r = -1;
        e_rh = '0; e_wh = '0; e_wd = '0; e_wi = '0; e_as = '0; e_ad = '0;
        rd_known = 1; last_rd = '0;
    endtask

    task automatic mid_reset();
        bit found;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (active && strobe_cyc > 0 && cyc > strobe_cyc && cyc < resp_cyc - 1) found = 1;
        end
        chk("rst_wait_found", 64'(found), 1);
        reset = 1'b0;
        req_valid = '0;
        dm_read_valid = 0; dm_write_ack = 0; dm_invalid_alloc = 0;
        dm_invalid_read = 0; dm_invalid_write = 0;
        #1;
        zero_chk("arst");
        repeat (2) begin
            @(negedge clk);
            zero_chk("rst_hold");
        end
        reset = 1'b1;
        model_reset();
        force_req = 4'b0101;
        step();
        chk("post_rst_grant", 64'(req_ready), 64'(4'b0001));
    endtask

    initial begin
        reset = 1'b0;
        req_valid = '0; req_op = '0; req_handle = '0; req_data = '0;
        req_inc = '0; req_size = '0; req_delay = '0;
        dm_data_out = '0; dm_read_valid = 0; dm_write_ack = 0;
        dm_invalid_alloc = 0; dm_invalid_read = 0; dm_invalid_write = 0;
        cyc = 0; did_to = 0; force_req = '0; req_pct = 25;
        op_m = 0; g_m = 0; strobe_cyc = -10; resp_cyc = -10; kind = 0; plan_k = 1;
        inv = 0; exp_err = 0; chk_d = 0; exp_rdata = '0; rd_val = '0;
        f_h = '0; f_d = '0; f_i = '0; f_s = '0; f_dl = '0;
        model_reset();
        repeat (2) @(negedge clk);
        zero_chk("por");
        reset = 1'b1;
        repeat (1200) step();
        mid_reset();
        req_pct = 75;
        repeat (1200) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/delay_request_arbiter.md
Name: delay_request_arbiter

Overview:
- Shares one delay_master port between n_req effect-pipeline requesters, such as per-voice delay, chorus and reverb stages.
- Accepts alloc, read and write operations from each requester and grants them round-robin.
- Issues exactly one operation at a time to delay_master and holds it until completion, error or timeout.
- Routes the result and any error back to the originating requester with a one-hot response strobe.

Parameters:
- n_req, 4, number of requesters (2..8).
- data_width, 16, sample width; matches delay_master.
- handle_width, 5, buffer handle width presented to delay_master.
- alloc_width, 24, width of alloc_size and alloc_delay.
- timeout_cycles, 63, maximum wait for completion before error.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  n_req  per-requester request pending.
- req_op  in  2*n_req  per-requester op: 00 read, 01 write, 10 alloc, 11 reserved.
- req_handle  in  handle_width*n_req  per-requester buffer handle.
- req_data  in  data_width*n_req  write sample.
- req_inc  in  data_width*n_req  signed delay increment (Q8 fractional samples).
- req_size  in  alloc_width*n_req  alloc size.
- req_delay  in  alloc_width*n_req  alloc initial delay (Q8).
- req_ready  out  n_req  one-hot grant; request fields are consumed in this cycle.
- resp_valid  out  n_req  one-hot completion strobe, 1 cycle.
- resp_data  out  data_width  read result, valid with resp_valid.
- resp_err  out  1  error flag, valid with resp_valid.
- dm_alloc_req, dm_read_req, dm_write_req  out  1 each  single-cycle strobes to delay_master.
- dm_alloc_size, dm_alloc_delay  out  alloc_width  alloc fields to delay_master.
- dm_read_handle, dm_write_handle  out  handle_width  handles to delay_master.
- dm_write_data, dm_write_inc  out  data_width  write fields to delay_master.
- dm_data_out  in  data_width  read data from delay_master.
- dm_read_valid, dm_write_ack  in  1  completion strobes from delay_master.
- dm_invalid_alloc, dm_invalid_read, dm_invalid_write  in  1  error strobes from delay_master.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs 0; FSM enters IDLE.
  - Round-robin pointer rr = 0; timeout counter = 0.
  - A reset asserted mid-operation abandons the transaction with no response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Scan req_valid starting at index rr, wrapping modulo n_req; the first set bit wins, index g.
  - Assert req_ready[g] for one cycle and latch that requester's op and fields.
  - Set rr <= (g+1) mod n_req. Go to ISSUE.
  - If no req_valid bit is set, stay in IDLE and leave rr unchanged.
- Reserved op 11: still granted. Skip ISSUE and go straight to RESP with resp_err=1, resp_data=0.
- ISSUE (1 cycle):
  - Pulse exactly one dm_*_req strobe.
  - Drive the latched fields on the matching dm_* buses; hold those buses stable until the next ISSUE.
  - Clear the timeout counter. Go to WAIT.
- WAIT, read: dm_read_valid completes with data = dm_data_out. dm_invalid_read completes with error.
- WAIT, write: dm_write_ack completes with no error. dm_invalid_write completes with error.
- WAIT, alloc: delay_master gives no success ack.
  - dm_invalid_alloc in the first WAIT cycle completes with error.
  - Otherwise the alloc completes successfully at the end of the second WAIT cycle.
- If a success strobe and an error strobe arrive in the same cycle, the error wins.
- Timeout: the counter increments each WAIT cycle. When it reaches timeout_cycles without completion, complete with resp_err=1, resp_data=0.
- RESP (1 cycle):
  - Drive resp_valid[g]=1 together with resp_data and resp_err.
  - Go to IDLE; a new grant is possible in the next cycle.
- Strobes from delay_master outside WAIT are ignored.
- resp_data holds its value between responses; resp_err is cleared when not in RESP.
- Minimum turnaround is 4 cycles per request (IDLE grant, ISSUE, WAIT ≥1, RESP).
- A requester must hold req_valid and its fields stable until req_ready. Deasserting req_valid before the grant withdraws the request.

Decomposition:
- Shared package (delay_pkg):
  - op codes OP_READ, OP_WRITE, OP_ALLOC, OP_RSVD.
  - FSM state constants.
  - DELAY_FORMAT = 8.
- Sub-module rr_arbiter: combinational round-robin priority encoder with inputs req vector and rr, outputs grant one-hot and index. It is reusable by other shared-resource schedulers.

Test Plan:
- Single read: req_valid=0001, op=00, handle=3; DM returns dm_read_valid with data 0x1234 three cycles after the strobe → dm_read_req pulses once with handle 3; resp_valid=0001, resp_data=0x1234, resp_err=0.
- Round-robin fairness: all four requesters issue writes continuously with immediate acks → grant order 0,1,2,3,0,1; no requester is granted twice before every other pending requester is granted once.
- Alloc outcomes:
  - Alloc with no invalid → resp_valid two WAIT cycles after the strobe, resp_err=0.
  - Repeat with dm_invalid_alloc in WAIT cycle 1 → resp_err=1.
- Timeout: read with no DM response → resp_err=1, resp_data=0 after 63 WAIT cycles; the next request is granted normally.
- Same-cycle error priority: dm_write_ack and dm_invalid_write pulsed together → resp_err=1.
- Async reset mid-WAIT: reset low for 2 cycles → all outputs 0 immediately; no resp_valid; rr=0; after release, requester 0 wins over requester 2 when both request.
